// File: rtl/branch_resolve_unit.sv
// Branch resolution at the end of EX: classifies each prediction,
// queues predictor training updates and requests fetch redirects.
module branch_resolve_unit #(
    parameter int UPD_DEPTH = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [31:0]          ex_pc,
    input  logic [1:0]           ex_btype,
    input  logic                 ex_pred_taken,
    input  logic [31:0]          ex_pred_pc,
    input  logic                 ex_taken,
    input  logic [31:0]          ex_target,

    output logic                 upd_valid,
    input  logic                 upd_ready,
    output logic [31:0]          fact_pc,
    output logic [31:0]          fact_tpc,
    output logic                 fact_taken,
    output logic                 predict_dir_fail,
    output logic                 predict_add_fail,

    output logic                 redir_valid,
    output logic [31:0]          redir_pc,
    input  logic                 redir_ready,

    output logic [CNT_WIDTH-1:0] cnt_branch,
    output logic [CNT_WIDTH-1:0] cnt_dir_fail,
    output logic [CNT_WIDTH-1:0] cnt_add_fail
);

    localparam int PW = $clog2(UPD_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(UPD_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_REDIR
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tpc;
        logic        taken;
        logic        dir_fail;
        logic        add_fail;
    } upd_ent_t;

    state_t         r_state;
    logic [31:0]    r_redir_pc;
    logic           r_redir_valid;

    upd_ent_t       r_mem [UPD_DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [PW:0]    r_count;

    logic [CNT_WIDTH-1:0] r_cnt_branch;
    logic [CNT_WIDTH-1:0] r_cnt_dir_fail;
    logic [CNT_WIDTH-1:0] r_cnt_add_fail;

    logic           w_full;
    logic           w_accept;
    logic           w_is_branch;
    logic           w_taken_eff;
    logic [31:0]    w_fall;
    logic [31:0]    w_actual;
    logic           w_dir_fail;
    logic           w_add_fail;
    logic           w_mispredict;
    logic           w_enq;
    logic           w_deq;
    upd_ent_t       w_new_ent;
    upd_ent_t       w_head;

    // Resolution: effective direction, next PC and failure classification
    always_comb begin
        w_full       = (r_count == FULL_CNT);
        ex_ready     = !w_full && (r_state == S_IDLE);
        w_accept     = ex_valid && ex_ready;
        w_is_branch  = (ex_btype != 2'b00);
        w_taken_eff  = w_is_branch && ex_taken;
        w_fall       = ex_pc[2] ? (ex_pc + 32'd4) : (ex_pc + 32'd8);
        w_actual     = w_taken_eff ? ex_target : w_fall;
        w_dir_fail   = (ex_pred_taken != w_taken_eff);
        w_add_fail   = w_taken_eff && ex_pred_taken
                       && (ex_pred_pc != ex_target);
        w_mispredict = w_dir_fail || w_add_fail;
        w_enq        = w_accept && (w_is_branch || ex_pred_taken);
        w_deq        = upd_valid && upd_ready;

        w_new_ent.pc       = ex_pc;
        w_new_ent.tpc      = ex_target;
        w_new_ent.taken    = w_taken_eff;
        w_new_ent.dir_fail = w_dir_fail;
        w_new_ent.add_fail = w_add_fail;
    end

    // Update FIFO storage; data needs no reset, validity comes from r_count
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wptr] <= w_new_ent;
        end
    end

    // Update FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_deq) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head           = r_mem[r_rptr];
    assign upd_valid        = (r_count != '0);
    assign fact_pc          = w_head.pc;
    assign fact_tpc         = w_head.tpc;
    assign fact_taken       = w_head.taken;
    assign predict_dir_fail = w_head.dir_fail;
    assign predict_add_fail = w_head.add_fail;

    // Redirect FSM: hold the corrected PC until fetch takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_mispredict) begin
                        r_state       <= S_REDIR;
                        r_redir_valid <= 1'b1;
                        r_redir_pc    <= w_actual;
                    end
                end
                S_REDIR: begin
                    if (redir_ready) begin
                        r_state       <= S_IDLE;
                        r_redir_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_redir_valid <= 1'b0;
                end
            endcase
        end
    end

    assign redir_valid = r_redir_valid;
    assign redir_pc    = r_redir_pc;

    // Statistics counters, free-running with wrap-around
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_branch   <= '0;
            r_cnt_dir_fail <= '0;
            r_cnt_add_fail <= '0;
        end else if (w_accept) begin
            if (w_is_branch) begin
                r_cnt_branch <= r_cnt_branch + CNT_WIDTH'(1);
            end
            if (w_dir_fail) begin
                r_cnt_dir_fail <= r_cnt_dir_fail + CNT_WIDTH'(1);
            end
            if (w_add_fail) begin
                r_cnt_add_fail <= r_cnt_add_fail + CNT_WIDTH'(1);
            end
        end
    end

    assign cnt_branch   = r_cnt_branch;
    assign cnt_dir_fail = r_cnt_dir_fail;
    assign cnt_add_fail = r_cnt_add_fail;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: vector table for resolution cases,
// hand-written sequences for back-pressure and async reset.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [1:0]  ex_btype;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] fact_pc;
    logic [31:0] fact_tpc;
    logic        fact_taken;
    logic        predict_dir_fail;
    logic        predict_add_fail;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;
    logic [31:0] cnt_branch;
    logic [31:0] cnt_dir_fail;
    logic [31:0] cnt_add_fail;

    branch_resolve_unit #(.UPD_DEPTH(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_btype(ex_btype),
        .ex_pred_taken(ex_pred_taken), .ex_pred_pc(ex_pred_pc),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .fact_pc(fact_pc), .fact_tpc(fact_tpc),
        .fact_taken(fact_taken),
        .predict_dir_fail(predict_dir_fail),
        .predict_add_fail(predict_add_fail),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .redir_ready(redir_ready),
        .cnt_branch(cnt_branch), .cnt_dir_fail(cnt_dir_fail),
        .cnt_add_fail(cnt_add_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  bt;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ppc;
        logic        tk;
        logic [31:0] tgt;
        logic        enq;
        logic        etk;
        logic        edf;
        logic        eaf;
        logic        misp;
        logic [31:0] rpc;
        int          hold;
        int          cb;
        int          cd;
        int          ca;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tpc;
        logic        tk;
        logic        df;
        logic        af;
    } ent_t;

    vec_t tbl [9];
    ent_t sbq [$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: pop and compare each head as it is consumed
    always @(negedge clk) begin
        if (!rst && upd_valid && upd_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_entry", fact_pc, 32'hFFFF_FFFF);
            end else begin
                ent_t e;
                e = sbq.pop_front();
                chk("fact_pc", fact_pc, e.pc);
                chk("fact_tpc", fact_tpc, e.tpc);
                chk("fact_taken", {31'd0, fact_taken}, {31'd0, e.tk});
                chk("dir_fail", {31'd0, predict_dir_fail}, {31'd0, e.df});
                chk("add_fail", {31'd0, predict_add_fail}, {31'd0, e.af});
            end
        end
    end

    task automatic drive(input vec_t v);
        ex_btype      = v.bt;
        ex_pc         = v.pc;
        ex_pred_taken = v.pt;
        ex_pred_pc    = v.ppc;
        ex_taken      = v.tk;
        ex_target     = v.tgt;
        ex_valid      = 1'b1;
    endtask

    task automatic push_exp(input vec_t v);
        ent_t e;
        e.pc  = v.pc;
        e.tpc = v.tgt;
        e.tk  = v.etk;
        e.df  = v.edf;
        e.af  = v.eaf;
        if (v.enq) sbq.push_back(e);
    endtask

    // Offer one instruction and return just after the accepting edge
    task automatic send(input vec_t v);
        int n;
        @(posedge clk); #1;
        drive(v);
        n = 0;
        @(negedge clk);
        while (!ex_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ex_ready) chk("accept_timeout", 32'd0, 32'd1);
        push_exp(v);
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    function automatic vec_t ok_br(input logic [31:0] pc);
        vec_t v;
        v = '{2'b10, pc, 1'b1, pc + 32'h40, 1'b1, pc + 32'h40,
              1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 0, 0, 0, 0};
        return v;
    endfunction

    initial begin
        int n;
        vec_t v;
        tbl[0] = '{2'b10, 32'h1C000000, 1'b1, 32'h1C000040, 1'b1,
                   32'h1C000040, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                   32'h0, 0, 1, 0, 0};
        tbl[1] = '{2'b10, 32'h1C000004, 1'b0, 32'h0, 1'b1,
                   32'h1C000100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                   32'h1C000100, 3, 2, 1, 0};
        tbl[2] = '{2'b00, 32'h1C000008, 1'b1, 32'h1C000010, 1'b1,
                   32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                   32'h1C000010, 0, 2, 2, 0};
        tbl[3] = '{2'b11, 32'h1C00000C, 1'b1, 32'h1C000200, 1'b1,
                   32'h1C000300, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                   32'h1C000300, 1, 3, 2, 1};
        tbl[4] = '{2'b10, 32'h1C000014, 1'b0, 32'h0, 1'b0,
                   32'h1C000500, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                   32'h0, 0, 4, 2, 1};
        tbl[5] = '{2'b00, 32'h1C000018, 1'b0, 32'h0, 1'b1,
                   32'h1C000700, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   32'h0, 0, 4, 2, 1};
        tbl[6] = '{2'b10, 32'h1C00001C, 1'b1, 32'h1C000600, 1'b0,
                   32'h1C000600, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                   32'h1C000020, 0, 5, 3, 1};
        tbl[7] = '{2'b10, 32'hFFFFFFF8, 1'b1, 32'h0, 1'b0,
                   32'h00000100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                   32'h00000000, 0, 6, 4, 1};
        tbl[8] = '{2'b01, 32'h1C000020, 1'b1, 32'h1C000800, 1'b1,
                   32'h1C000800, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                   32'h0, 0, 7, 4, 1};

        rst = 1'b1;
        ex_valid = 0; ex_pc = 0; ex_btype = 0; ex_pred_taken = 0;
        ex_pred_pc = 0; ex_taken = 0; ex_target = 0;
        upd_ready = 1'b1; redir_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
        chk("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
        chk("rst_redir_pc", redir_pc, 32'd0);
        chk("rst_cnt_branch", cnt_branch, 32'd0);
        chk("rst_cnt_dir", cnt_dir_fail, 32'd0);
        chk("rst_cnt_add", cnt_add_fail, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            send(tbl[i]);
            @(negedge clk);
            chk("redir_valid", {31'd0, redir_valid}, {31'd0, tbl[i].misp});
            if (tbl[i].misp) begin
                chk("redir_pc", redir_pc, tbl[i].rpc);
                chk("ready_in_redir", {31'd0, ex_ready}, 32'd0);
                for (int h = 0; h < tbl[i].hold; h++) begin
                    @(negedge clk);
                    chk("redir_pc_hold", redir_pc, tbl[i].rpc);
                    chk("redir_valid_hold", {31'd0, redir_valid}, 32'd1);
                    chk("ready_hold", {31'd0, ex_ready}, 32'd0);
                end
                @(posedge clk); #1 redir_ready = 1'b1;
                @(posedge clk); #1 redir_ready = 1'b0;
                @(negedge clk);
                chk("redir_release", {31'd0, redir_valid}, 32'd0);
                chk("ready_after", {31'd0, ex_ready}, 32'd1);
            end
            chk("cnt_branch", cnt_branch, tbl[i].cb);
            chk("cnt_dir_fail", cnt_dir_fail, tbl[i].cd);
            chk("cnt_add_fail", cnt_add_fail, tbl[i].ca);
        end

        // Back-pressure: fill the FIFO, then free one slot
        @(posedge clk); #1 upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(ok_br(32'h2000_0000 + i * 16));
        @(negedge clk);
        chk("full_ex_ready", {31'd0, ex_ready}, 32'd0);
        chk("full_upd_valid", {31'd0, upd_valid}, 32'd1);
        v = ok_br(32'h2000_0100);
        @(posedge clk); #1;
        drive(v);
        upd_ready = 1'b1;
        @(negedge clk);
        chk("deq_first_ready", {31'd0, ex_ready}, 32'd0);
        @(posedge clk); #1 upd_ready = 1'b0;
        @(negedge clk);
        chk("after_deq_ready", {31'd0, ex_ready}, 32'd1);
        push_exp(v);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        upd_ready = 1'b1;
        n = 0;
        while (sbq.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", sbq.size(), 32'd0);
        @(negedge clk);
        chk("drain_upd_valid", {31'd0, upd_valid}, 32'd0);
        chk("cnt_branch_fill", cnt_branch, 32'd12);

        // Async reset mid-redirect with two queued entries
        @(posedge clk); #1 upd_ready = 1'b0;
        send(tbl[0]);
        send(tbl[1]);
        @(negedge clk);
        chk("pre_rst_redir", {31'd0, redir_valid}, 32'd1);
        chk("pre_rst_upd", {31'd0, upd_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_redir_valid", {31'd0, redir_valid}, 32'd0);
        chk("arst_redir_pc", redir_pc, 32'd0);
        chk("arst_upd_valid", {31'd0, upd_valid}, 32'd0);
        chk("arst_cnt_branch", cnt_branch, 32'd0);
        chk("arst_cnt_dir", cnt_dir_fail, 32'd0);
        chk("arst_cnt_add", cnt_add_fail, 32'd0);
        sbq.delete();
        #1 rst = 1'b0;
        upd_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, ex_ready}, 32'd1);
        chk("post_rst_upd", {31'd0, upd_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_miss);
        $finish;
    end

endmodule
